// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and the IROM.
// The fetch unit drives req/addr; the memory answers with gnt, then rvalid/rdata.
interface inst_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch unit: request, wait for the response, hold
// the instruction for decode, then latch the externally computed next PC.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    inst_fetch_if.master        irom,
    input  logic [31:0]         npc,
    input  logic                inst_ready,
    output logic [31:0]         pc,
    output logic [31:0]         inst,
    output logic                inst_valid,
    output logic [31:0]         instret,
    output logic                fetch_err
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    // TIMEOUT is bounded to 1..65535, so the last count before giving up fits 16 bits.
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] tcnt;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            inst      <= NOP_INST;
            instret   <= 32'd0;
            fetch_err <= 1'b0;
            tcnt      <= 16'd0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (irom.gnt) begin
                        state <= ST_WAIT;
                        tcnt  <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    // A response on the final allowed cycle still beats the timeout.
                    if (irom.rvalid) begin
                        inst  <= irom.rdata;
                        state <= ST_HOLD;
                    end else if (tcnt == TCNT_LAST) begin
                        state     <= ST_ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        // npc is latched even when misaligned so the bad target is visible.
                        pc      <= npc;
                        instret <= instret + 32'd1;
                        if (npc[1:0] != 2'b00) begin
                            state     <= ST_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state     <= ST_ERR;
                    fetch_err <= 1'b1;
                end
            endcase
        end
    end

    assign irom.req   = (state == ST_REQ);
    assign irom.addr  = pc;
    assign inst_valid = (state == ST_HOLD);

    a_req_valid_excl: assert property (@(posedge cpu_clk) !(irom.req && inst_valid));

    a_err_sticky: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        fetch_err |=> fetch_err);

    a_hold_stable: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        (inst_valid && !inst_ready) |=> (inst_valid && $stable(inst) && $stable(pc)));

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000: the PC value loaded on reset SHALL be this parameter.
REQ-002 TIMEOUT, 16: the maximum number of cycles from grant to response SHALL be this parameter, with a range of 1..65535.
REQ-003 cpu_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 cpu_rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 npc  in  32  SHALL carry the next PC from the next-PC logic and is valid while inst_valid is high.
REQ-006 inst_ready  in  1  SHALL indicate that decode/execute accepts the current instruction (retire).
REQ-007 irom_req  out  1  SHALL be the fetch request to instruction memory.
REQ-008 irom_addr  out  32  SHALL be the fetch address and SHALL equal pc.
REQ-009 irom_gnt  in  1  SHALL indicate that memory accepted the request in this cycle.
REQ-010 irom_rvalid  in  1  SHALL indicate that the read data is valid in this cycle.
REQ-011 irom_rdata  in  32  SHALL carry the instruction word.
REQ-012 pc  out  32  SHALL be the PC of the instruction being fetched or held.
REQ-013 inst  out  32  SHALL be the registered instruction word.
REQ-014 inst_valid  out  1  SHALL indicate that inst and pc form a valid pair for decode.
REQ-015 instret  out  32  SHALL count retired instructions.
REQ-016 fetch_err  out  1  SHALL be a sticky error flag, set on a misaligned npc or a response timeout.

Function
REQ-017 The FSM SHALL have exactly these states: REQ, WAIT, HOLD, ERR.
REQ-018 REQ: irom_req=1 and irom_addr=pc, both held stable until irom_gnt; on irom_gnt the FSM SHALL go to WAIT.
REQ-019 WAIT: irom_req=0; on irom_rvalid the block SHALL set inst<=irom_rdata and go to HOLD.
REQ-020 An irom_rvalid in the same cycle as irom_gnt SHALL be ignored; the earliest accepted response is one cycle after the grant.
REQ-021 HOLD: inst_valid=1, with inst and pc stable until inst_ready.
REQ-022 On HOLD with inst_ready, the block SHALL set pc<=npc and instret<=instret+1, then go to REQ, or to ERR if npc[1:0]!=2'b00.
REQ-023 On a misaligned npc, pc SHALL still load npc so it is visible for debug, and instret SHALL still increment.
REQ-024 ERR: irom_req=0, inst_valid=0, fetch_err=1; the FSM SHALL leave ERR only through cpu_rst.
REQ-025 inst_valid SHALL be 1 only in HOLD; irom_req SHALL be 1 only in REQ.
REQ-026 irom_rvalid SHALL be ignored in REQ, HOLD and ERR, since at most one request is outstanding.
REQ-027 Timeout counter: cleared on entry to WAIT and incremented each WAIT cycle without irom_rvalid.
REQ-028 If the timeout counter reaches TIMEOUT without irom_rvalid, the FSM SHALL go to ERR.
REQ-029 If irom_rvalid arrives on the same cycle the count reaches TIMEOUT, the response SHALL win and the FSM SHALL go to HOLD.
REQ-030 There SHALL be no bound on the wait for irom_gnt in REQ.
REQ-031 instret SHALL be a 32-bit counter that wraps from 32'hFFFF_FFFF to 0 without any flag.
REQ-032 The pc increment is owned by the next-PC logic; this block SHALL perform no PC arithmetic and SHALL only latch npc.
REQ-033 Throughput with zero-wait memory and decode SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD).

Reset
REQ-034 While cpu_rst=1 at a clock edge, the block SHALL load: state=REQ, pc=RESET_PC, inst=32'h0000_0013 (NOP), instret=0, fetch_err=0, timeout counter=0.
REQ-035 Outputs in the first cycle after reset SHALL be: irom_req=1, irom_addr=RESET_PC, inst_valid=0.
REQ-036 Reset SHALL override every state, including ERR and mid-WAIT.
REQ-037 A response to a request issued before reset that arrives after reset SHALL be ignored while in REQ.
REQ-038 Outputs SHALL depend only on the registered state and pc, with no combinational path from irom_* inputs to outputs, except that irom_req depends on state only.

Verification
REQ-039 Zero-wait run: gnt=1, rvalid one cycle after gnt, inst_ready=1, npc=pc+4 -> pc sequence 0,4,8; inst_valid pulses every 3rd cycle; instret=3 after 9 cycles.
REQ-040 Backpressure: inst_ready held 0 for 5 cycles in HOLD -> inst and pc stable, inst_valid=1 throughout, instret unchanged, no irom_req.
REQ-041 Slow memory: gnt delayed 4 cycles and rvalid delayed 3 cycles -> irom_addr stable during REQ, response captured, no fetch_err.
REQ-042 Timeout: TIMEOUT=4 with no rvalid -> ERR entered exactly 4 cycles after WAIT entry, fetch_err=1, irom_req=0.
REQ-043 Timeout boundary: TIMEOUT=4 with rvalid on the 4th WAIT cycle -> HOLD entered, no error.
REQ-044 Misaligned jump: npc=32'h0000_0102 at retire -> pc=32'h0000_0102, fetch_err=1, no further requests; a subsequent cpu_rst pulse -> pc=RESET_PC, fetch_err=0, irom_req=1.
